// File: rtl/ic1500_sequencer_if.sv
// Requester handshake and shared flip-flop resource signals for ic1500_sequencer.
// The slave modport is the sequencer; the master modport is the requester/resource side.
interface ic1500_sequencer_if;
    logic       req0;
    logic [3:0] cmd0;
    logic       gnt0;
    logic       done0;
    logic [2:0] rsp0;
    logic       req1;
    logic [3:0] cmd1;
    logic       gnt1;
    logic       done1;
    logic [2:0] rsp1;
    logic       d0;
    logic       f0;
    logic       d1;
    logic       f1;
    logic       q0;
    logic       q1;
    logic       y;
    logic       busy;

    modport master (
        output req0, cmd0, req1, cmd1, q0, q1, y,
        input  gnt0, done0, rsp0, gnt1, done1, rsp1, d0, f0, d1, f1, busy
    );

    modport slave (
        input  req0, cmd0, req1, cmd1, q0, q1, y,
        output gnt0, done0, rsp0, gnt1, done1, rsp1, d0, f0, d1, f1, busy
    );
endinterface

// File: rtl/ic1500_sequencer.sv
// Round-robin sequencer sharing one dual flip-flop resource between two requesters:
// drives the winner's control pattern for HOLD_CYCLES, then samples {q0,q1,y} back.
//
// state  | meaning
// IDLE   | resource parked at IDLE_VEC, arbitrating incoming requests
// DRIVE  | winner's pattern applied, hold_cnt counting down to 1
// SAMPLE | pattern still applied; next edge captures {q0,q1,y} and pulses done
module ic1500_sequencer #(
    parameter int unsigned HOLD_CYCLES = 1,
    parameter logic [3:0]  IDLE_VEC    = 4'b0000
) (
    input logic                 clk,
    input logic                 rst_n,
    ic1500_sequencer_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE} state_t;

    state_t     state;
    logic [3:0] hold_cnt;
    logic [3:0] cmd_reg;
    logic       owner;
    logic       last_winner;
    logic       win;
    logic       gnt0_r, gnt1_r, done0_r, done1_r, busy_r;
    logic [2:0] rsp0_r, rsp1_r;

    // A lone request wins outright; a tie goes to whoever did not win last.
    always_comb begin
        win = bus.req1;
        if (bus.req0 && bus.req1) begin
            win = ~last_winner;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            hold_cnt    <= 4'd0;
            cmd_reg     <= IDLE_VEC;
            owner       <= 1'b0;
            last_winner <= 1'b1;
            gnt0_r      <= 1'b0;
            gnt1_r      <= 1'b0;
            done0_r     <= 1'b0;
            done1_r     <= 1'b0;
            busy_r      <= 1'b0;
            rsp0_r      <= 3'b000;
            rsp1_r      <= 3'b000;
        end else begin
            gnt0_r  <= 1'b0;
            gnt1_r  <= 1'b0;
            done0_r <= 1'b0;
            done1_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req0 || bus.req1) begin
                        owner       <= win;
                        last_winner <= win;
                        cmd_reg     <= win ? bus.cmd1 : bus.cmd0;
                        gnt0_r      <= ~win;
                        gnt1_r      <= win;
                        hold_cnt    <= 4'(HOLD_CYCLES);
                        busy_r      <= 1'b1;
                        state       <= DRIVE;
                    end
                end
                DRIVE: begin
                    hold_cnt <= hold_cnt - 4'd1;
                    if (hold_cnt == 4'd1) begin
                        state <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    if (owner) begin
                        rsp1_r  <= {bus.q0, bus.q1, bus.y};
                        done1_r <= 1'b1;
                    end else begin
                        rsp0_r  <= {bus.q0, bus.q1, bus.y};
                        done0_r <= 1'b1;
                    end
                    cmd_reg <= IDLE_VEC;
                    busy_r  <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    cmd_reg <= IDLE_VEC;
                    busy_r  <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    assign bus.gnt0  = gnt0_r;
    assign bus.gnt1  = gnt1_r;
    assign bus.done0 = done0_r;
    assign bus.done1 = done1_r;
    assign bus.rsp0  = rsp0_r;
    assign bus.rsp1  = rsp1_r;
    assign bus.busy  = busy_r;
    assign {bus.d0, bus.f0, bus.d1, bus.f1} = cmd_reg;
endmodule
